// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - decode-to-execute handshake, operand and forwarding bundle
interface id_ex_stage_if;
    logic        InValid;
    logic        InReady;
    logic        OutValid;
    logic        OutReady;
    logic        Flush;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic [4:0]  Rs;
    logic [4:0]  Rt;
    logic [4:0]  Rd;
    logic [4:0]  Shamt;
    logic [15:0] Imm;
    logic        SignExt;
    logic        ALUSrc;
    logic        ShiftSrc;
    logic [2:0]  ALUControlIn;
    logic        RegWriteIn;
    logic        MemRegWrite;
    logic [4:0]  MemRd;
    logic [31:0] MemResult;
    logic        WbRegWrite;
    logic [4:0]  WbRd;
    logic [31:0] WbResult;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [2:0]  ALUControl;
    logic [4:0]  WriteRegE;
    logic        RegWriteE;

    modport master (
        output InValid, OutReady, Flush, RD1, RD2, Rs, Rt, Rd, Shamt, Imm, SignExt,
               ALUSrc, ShiftSrc, ALUControlIn, RegWriteIn,
               MemRegWrite, MemRd, MemResult, WbRegWrite, WbRd, WbResult,
        input  InReady, OutValid, SrcA, SrcB, ALUControl, WriteRegE, RegWriteE
    );

    modport slave (
        input  InValid, OutReady, Flush, RD1, RD2, Rs, Rt, Rd, Shamt, Imm, SignExt,
               ALUSrc, ShiftSrc, ALUControlIn, RegWriteIn,
               MemRegWrite, MemRd, MemResult, WbRegWrite, WbRd, WbResult,
        output InReady, OutValid, SrcA, SrcB, ALUControl, WriteRegE, RegWriteE
    );
endinterface

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - one-entry ID/EX pipeline register with operand muxing
// Optional macro ID_EX_FORWARD_EN enables EX/MEM and MEM/WB forwarding plus WB write-through.
module id_ex_stage (
    input  logic          clk,
    input  logic          rst_n,
    id_ex_stage_if.slave  bus
);
    logic        valid_q;
    logic [31:0] rd1_q;
    logic [31:0] rd2_q;
    logic [4:0]  rs_q;
    logic [4:0]  rt_q;
    logic [4:0]  rd_q;
    logic [4:0]  shamt_q;
    logic [31:0] imm_q;
    logic        alusrc_q;
    logic        shiftsrc_q;
    logic [2:0]  aluctl_q;
    logic        regwrite_q;

    logic [31:0] imm_ext;
    logic        in_ready;
    logic        load;
    logic [31:0] fwd_a;
    logic [31:0] fwd_b;

    assign imm_ext  = bus.SignExt ? {{16{bus.Imm[15]}}, bus.Imm} : {16'b0, bus.Imm};
    assign in_ready = !valid_q || bus.OutReady;
    assign load     = bus.InValid && in_ready && !bus.Flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            rd1_q      <= 32'b0;
            rd2_q      <= 32'b0;
            rs_q       <= 5'b0;
            rt_q       <= 5'b0;
            rd_q       <= 5'b0;
            shamt_q    <= 5'b0;
            imm_q      <= 32'b0;
            alusrc_q   <= 1'b0;
            shiftsrc_q <= 1'b0;
            aluctl_q   <= 3'b0;
            regwrite_q <= 1'b0;
        end else begin
            // Flush wins over a same-edge load: the incoming instruction is dropped.
            if (bus.Flush)
                valid_q <= 1'b0;
            else if (load)
                valid_q <= 1'b1;
            else if (valid_q && bus.OutReady)
                valid_q <= 1'b0;

            if (load) begin
                rd1_q      <= bus.RD1;
                rd2_q      <= bus.RD2;
                rs_q       <= bus.Rs;
                rt_q       <= bus.Rt;
                rd_q       <= bus.Rd;
                shamt_q    <= bus.Shamt;
                imm_q      <= imm_ext;
                alusrc_q   <= bus.ALUSrc;
                shiftsrc_q <= bus.ShiftSrc;
                aluctl_q   <= bus.ALUControlIn;
                regwrite_q <= bus.RegWriteIn;
            end
`ifdef ID_EX_FORWARD_EN
            else begin
                // Absorb WB results so a stalled operand stays current after WB moves on.
                if (bus.WbRegWrite && (bus.WbRd == rs_q) && (rs_q != 5'd0))
                    rd1_q <= bus.WbResult;
                if (bus.WbRegWrite && (bus.WbRd == rt_q) && (rt_q != 5'd0))
                    rd2_q <= bus.WbResult;
            end
`endif
        end
    end

`ifdef ID_EX_FORWARD_EN
    always_comb begin
        fwd_a = rd1_q;
        if (bus.MemRegWrite && (bus.MemRd == rs_q) && (rs_q != 5'd0))
            fwd_a = bus.MemResult;
        else if (bus.WbRegWrite && (bus.WbRd == rs_q) && (rs_q != 5'd0))
            fwd_a = bus.WbResult;
    end

    always_comb begin
        fwd_b = rd2_q;
        if (bus.MemRegWrite && (bus.MemRd == rt_q) && (rt_q != 5'd0))
            fwd_b = bus.MemResult;
        else if (bus.WbRegWrite && (bus.WbRd == rt_q) && (rt_q != 5'd0))
            fwd_b = bus.WbResult;
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{bus.MemRegWrite, bus.MemRd, bus.MemResult,
                          bus.WbRegWrite, bus.WbRd, bus.WbResult};
    assign fwd_a = rd1_q;
    assign fwd_b = rd2_q;
`endif

    // A bubble presents neutral operands and ALU op 7 so the ALU yields zero.
    always_comb begin
        bus.InReady    = in_ready;
        bus.OutValid   = valid_q;
        bus.SrcA       = 32'b0;
        bus.SrcB       = 32'b0;
        bus.ALUControl = 3'd7;
        bus.WriteRegE  = 5'b0;
        bus.RegWriteE  = 1'b0;
        if (valid_q) begin
            bus.SrcA       = shiftsrc_q ? {27'b0, shamt_q} : fwd_a;
            bus.SrcB       = alusrc_q ? imm_q : fwd_b;
            bus.ALUControl = aluctl_q;
            bus.WriteRegE  = rd_q;
            bus.RegWriteE  = regwrite_q;
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

`ifdef ID_EX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle;
        bus.InValid = 0; bus.OutReady = 0; bus.Flush = 0;
        bus.RD1 = 0; bus.RD2 = 0; bus.Rs = 0; bus.Rt = 0; bus.Rd = 0;
        bus.Shamt = 0; bus.Imm = 0; bus.SignExt = 0; bus.ALUSrc = 0; bus.ShiftSrc = 0;
        bus.ALUControlIn = 0; bus.RegWriteIn = 0;
        bus.MemRegWrite = 0; bus.MemRd = 0; bus.MemResult = 0;
        bus.WbRegWrite = 0; bus.WbRd = 0; bus.WbResult = 0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive_idle();
        #3;
        vectors++; if (bus.OutValid !== 1'b0) begin miscompares++; $display("FAIL reset_outvalid: got %b expected 0", bus.OutValid); end
        vectors++; if (bus.InReady !== 1'b1) begin miscompares++; $display("FAIL reset_inready: got %b expected 1", bus.InReady); end
        vectors++; if (bus.SrcA !== 32'h0 || bus.SrcB !== 32'h0) begin miscompares++; $display("FAIL reset_src: got %h/%h expected 0/0", bus.SrcA, bus.SrcB); end
        vectors++; if (bus.ALUControl !== 3'd7) begin miscompares++; $display("FAIL reset_aluctl: got %0d expected 7", bus.ALUControl); end
        vectors++; if (bus.RegWriteE !== 1'b0 || bus.WriteRegE !== 5'd0) begin miscompares++; $display("FAIL reset_wr: got %b/%0d expected 0/0", bus.RegWriteE, bus.WriteRegE); end
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic;
        bus.InValid = 1; bus.OutReady = 1; bus.RD1 = 32'd5; bus.RD2 = 32'd7;
        bus.Rs = 5'd1; bus.Rt = 5'd2; bus.Rd = 5'd9; bus.ALUControlIn = 3'd2; bus.RegWriteIn = 1;
        tick();
        bus.InValid = 0;
        vectors++; if (bus.OutValid !== 1'b1) begin miscompares++; $display("FAIL basic_outvalid: got %b expected 1", bus.OutValid); end
        vectors++; if (bus.SrcA !== 32'd5 || bus.SrcB !== 32'd7) begin miscompares++; $display("FAIL basic_src: got %h/%h expected 5/7", bus.SrcA, bus.SrcB); end
        vectors++; if (bus.ALUControl !== 3'd2) begin miscompares++; $display("FAIL basic_aluctl: got %0d expected 2", bus.ALUControl); end
        vectors++; if (bus.WriteRegE !== 5'd9 || bus.RegWriteE !== 1'b1) begin miscompares++; $display("FAIL basic_wr: got %0d/%b expected 9/1", bus.WriteRegE, bus.RegWriteE); end
        tick();
        vectors++; if (bus.OutValid !== 1'b0 || bus.ALUControl !== 3'd7 || bus.SrcA !== 32'h0) begin miscompares++; $display("FAIL basic_bubble: got v=%b alu=%0d a=%h expected v=0 alu=7 a=0", bus.OutValid, bus.ALUControl, bus.SrcA); end
        drive_idle();
    endtask

    task automatic test_forward;
        bus.InValid = 1; bus.OutReady = 1; bus.Rs = 5'd3; bus.RD1 = 32'h11; bus.ALUControlIn = 3'd1;
        tick();
        bus.InValid = 0; bus.OutReady = 0;
        bus.MemRegWrite = 1; bus.MemRd = 5'd3; bus.MemResult = 32'hAA;
        bus.WbRegWrite = 1; bus.WbRd = 5'd3; bus.WbResult = 32'hBB;
        #1;
        vectors++; if (bus.SrcA !== (FWD ? 32'hAA : 32'h11)) begin miscompares++; $display("FAIL fwd_mem_priority: got %h expected %h", bus.SrcA, FWD ? 32'hAA : 32'h11); end
        bus.MemRegWrite = 0;
        #1;
        vectors++; if (bus.SrcA !== (FWD ? 32'hBB : 32'h11)) begin miscompares++; $display("FAIL fwd_wb: got %h expected %h", bus.SrcA, FWD ? 32'hBB : 32'h11); end
        bus.InValid = 1; bus.OutReady = 1; bus.Rs = 5'd0; bus.RD1 = 32'h22;
        bus.MemRegWrite = 1; bus.MemRd = 5'd0; bus.WbRd = 5'd0;
        tick();
        bus.InValid = 0;
        vectors++; if (bus.SrcA !== 32'h22) begin miscompares++; $display("FAIL fwd_reg0: got %h expected 00000022", bus.SrcA); end
        tick();
        drive_idle();
    endtask

    task automatic test_imm_back_to_back;
        bus.InValid = 1; bus.OutReady = 1; bus.ALUSrc = 1; bus.Imm = 16'h8000; bus.SignExt = 1;
        tick();
        vectors++; if (bus.SrcB !== 32'hFFFF8000) begin miscompares++; $display("FAIL imm_sext: got %h expected ffff8000", bus.SrcB); end
        bus.SignExt = 0;
        tick();
        vectors++; if (bus.SrcB !== 32'h00008000 || bus.OutValid !== 1'b1) begin miscompares++; $display("FAIL imm_zext: got %h v=%b expected 00008000 v=1", bus.SrcB, bus.OutValid); end
        bus.ALUSrc = 0; bus.ShiftSrc = 1; bus.Shamt = 5'd4; bus.RD1 = 32'hDEAD;
        tick();
        bus.InValid = 0;
        vectors++; if (bus.SrcA !== 32'd4) begin miscompares++; $display("FAIL shamt_srca: got %h expected 4", bus.SrcA); end
        tick();
        drive_idle();
    endtask

    task automatic test_stall_writethrough;
        bus.InValid = 1; bus.OutReady = 1; bus.Rt = 5'd6; bus.RD2 = 32'h33; bus.ALUControlIn = 3'd3;
        tick();
        bus.OutReady = 0; bus.RD2 = 32'h99; bus.ALUControlIn = 3'd5;
        bus.WbRegWrite = 1; bus.WbRd = 5'd6; bus.WbResult = 32'h55;
        #1;
        vectors++; if (bus.SrcB !== (FWD ? 32'h55 : 32'h33)) begin miscompares++; $display("FAIL stall_c1_srcb: got %h expected %h", bus.SrcB, FWD ? 32'h55 : 32'h33); end
        vectors++; if (bus.InReady !== 1'b0) begin miscompares++; $display("FAIL stall_c1_inready: got %b expected 0", bus.InReady); end
        tick();
        bus.WbRegWrite = 0; bus.WbResult = 32'h0;
        #1;
        vectors++; if (bus.SrcB !== (FWD ? 32'h55 : 32'h33)) begin miscompares++; $display("FAIL stall_c2_srcb: got %h expected %h", bus.SrcB, FWD ? 32'h55 : 32'h33); end
        vectors++; if (bus.InReady !== 1'b0) begin miscompares++; $display("FAIL stall_c2_inready: got %b expected 0", bus.InReady); end
        tick();
        vectors++; if (bus.SrcB !== (FWD ? 32'h55 : 32'h33)) begin miscompares++; $display("FAIL stall_c3_srcb: got %h expected %h", bus.SrcB, FWD ? 32'h55 : 32'h33); end
        vectors++; if (bus.ALUControl !== 3'd3 || bus.OutValid !== 1'b1 || bus.InReady !== 1'b0) begin miscompares++; $display("FAIL stall_c3_hold: got alu=%0d v=%b rdy=%b expected alu=3 v=1 rdy=0", bus.ALUControl, bus.OutValid, bus.InReady); end
        bus.InValid = 0; bus.OutReady = 1;
        tick();
        vectors++; if (bus.OutValid !== 1'b0) begin miscompares++; $display("FAIL stall_release: got %b expected 0", bus.OutValid); end
        drive_idle();
    endtask

    task automatic test_flush;
        bus.InValid = 1; bus.OutReady = 1; bus.RD1 = 32'h44; bus.Rd = 5'd5; bus.RegWriteIn = 1;
        tick();
        vectors++; if (bus.OutValid !== 1'b1 || bus.RegWriteE !== 1'b1) begin miscompares++; $display("FAIL flush_pre: got v=%b rw=%b expected 1/1", bus.OutValid, bus.RegWriteE); end
        bus.Flush = 1; bus.RD1 = 32'h77; bus.Rd = 5'd8;
        tick();
        bus.Flush = 0; bus.InValid = 0;
        vectors++; if (bus.OutValid !== 1'b0 || bus.RegWriteE !== 1'b0 || bus.SrcA !== 32'h0) begin miscompares++; $display("FAIL flush_drop: got v=%b rw=%b a=%h expected 0/0/0", bus.OutValid, bus.RegWriteE, bus.SrcA); end
        tick();
        vectors++; if (bus.OutValid !== 1'b0) begin miscompares++; $display("FAIL flush_no_capture: got %b expected 0", bus.OutValid); end
        drive_idle();
    endtask

    task automatic test_async_reset;
        bus.InValid = 1; bus.OutReady = 1; bus.RD1 = 32'h5A; bus.ALUControlIn = 3'd4;
        tick();
        bus.InValid = 0; bus.OutReady = 0;
        vectors++; if (bus.OutValid !== 1'b1 || bus.SrcA !== 32'h5A) begin miscompares++; $display("FAIL areset_pre: got v=%b a=%h expected 1/5a", bus.OutValid, bus.SrcA); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (bus.OutValid !== 1'b0 || bus.SrcA !== 32'h0 || bus.ALUControl !== 3'd7) begin miscompares++; $display("FAIL areset_now: got v=%b a=%h alu=%0d expected 0/0/7", bus.OutValid, bus.SrcA, bus.ALUControl); end
        vectors++; if (bus.InReady !== 1'b1) begin miscompares++; $display("FAIL areset_inready: got %b expected 1", bus.InReady); end
        #1 rst_n = 1'b1;
        bus.InValid = 1; bus.RD1 = 32'h66; bus.ALUControlIn = 3'd1;
        tick();
        bus.InValid = 0;
        vectors++; if (bus.OutValid !== 1'b1 || bus.SrcA !== 32'h66 || bus.ALUControl !== 3'd1) begin miscompares++; $display("FAIL areset_reload: got v=%b a=%h alu=%0d expected 1/66/1", bus.OutValid, bus.SrcA, bus.ALUControl); end
        drive_idle();
        tick();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_forward();
        test_imm_back_to_back();
        test_stall_writethrough();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 clk  in  1  rising-edge clock; sole clock.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 InValid / InReady  in / out  1 / 1  decode-side handshake; transfer when both high on a clk edge.
REQ-004 OutValid / OutReady  out / in  1 / 1  ALU-side handshake; instruction retires from stage when both high.
REQ-005 Flush  in  1  discard held instruction (branch/jump redirect).
REQ-006 RD1, RD2  in  32  register-file read data for Rs, Rt.
REQ-007 Rs, Rt, Rd  in  5  source/destination register numbers.
REQ-008 Shamt  in  5;  Imm  in  16;  SignExt  in  1 (1 = sign-extend Imm, 0 = zero-extend).
REQ-009 ALUSrc  in  1  (SrcB = extended Imm);  ShiftSrc  in  1  (SrcA = zero-extended Shamt).
REQ-010 ALUControlIn  in  3;  RegWriteIn  in  1.
REQ-011 MemRegWrite, MemRd, MemResult  in  1/5/32  EX/MEM forwarding source.
REQ-012 WbRegWrite, WbRd, WbResult  in  1/5/32  MEM/WB forwarding source.
REQ-013 SrcA, SrcB  out  32;  ALUControl  out  3;  WriteRegE  out  5;  RegWriteE  out  1.

Function
REQ-014 Stage SHALL hold one instruction; InReady = !OutValid | OutReady (combinational).
REQ-015 Load on edge when InValid & InReady & !Flush: capture RD1, RD2, Rs, Rt, Rd, Shamt, extended Imm (32b), ALUSrc, ShiftSrc, ALUControlIn, RegWriteIn; OutValid <= 1.
REQ-016 If OutValid & OutReady and no load, OutValid <= 0 next edge; if OutValid & !OutReady, all captured fields SHALL hold.
REQ-017 Flush SHALL clear OutValid on the next edge and take priority over a simultaneous load (incoming instruction dropped).
REQ-018 Imm extension: SignExt=1 -> {16{Imm[15]},Imm}; SignExt=0 -> {16'b0,Imm}.
REQ-019 Operand A (combinational): ShiftSrc -> {27'b0,Shamt}; else forwarded value of Rs.
REQ-020 Operand B (combinational): ALUSrc -> extended Imm; else forwarded value of Rt.
REQ-021 Forwarded value of Rx: MemRegWrite & MemRd==Rx & Rx!=0 -> MemResult; else WbRegWrite & WbRd==Rx & Rx!=0 -> WbResult; else captured RDx. EX/MEM priority over MEM/WB.
REQ-022 Register 0 SHALL never be forwarded.
REQ-023 Write-through: on any edge without a load, if WbRegWrite & WbRd==captured Rs & Rs!=0, captured RD1 <= WbResult; same for Rt/RD2 (keeps stalled operands current after WB leaves).
REQ-024 When OutValid=0 (bubble): SrcA=0, SrcB=0, ALUControl=3'd7 (ALU yields 0), RegWriteE=0, WriteRegE=0.
REQ-025 When OutValid=1: ALUControl, WriteRegE, RegWriteE SHALL equal captured values.
REQ-026 Latency: captured instruction visible on outputs one cycle after the load edge.

Reset
REQ-027 rst_n low SHALL immediately clear OutValid and all captured fields to 0 regardless of clk; outputs per REQ-024, InReady=1.
REQ-028 Reset mid-stall SHALL discard the held instruction; first edge after release may load.

Configuration
REQ-029 Macro ID_EX_FORWARD_EN: defined -> REQ-021 and REQ-023 active.
REQ-030 Undefined -> forwarded value of Rx = captured RDx; Mem*/Wb* inputs ignored; no write-through; hazard stalls are the upstream's responsibility.

Verification
REQ-031 Load RD1=5, RD2=7, ALUControlIn=2, OutReady=1 -> next cycle SrcA=5, SrcB=7, ALUControl=2, OutValid=1; following cycle bubble (ALUControl=7).
REQ-032 Rs=3, MemRegWrite=1, MemRd=3, MemResult=0xAA, WbRd=3, WbResult=0xBB -> SrcA=0xAA; MemRegWrite=0 -> SrcA=0xBB; Rs=0 with both matching -> SrcA=RD1.
REQ-033 ALUSrc=1, Imm=0x8000, SignExt=1 -> SrcB=0xFFFF8000; SignExt=0 -> 0x00008000; ShiftSrc=1, Shamt=4 -> SrcA=4.
REQ-034 OutReady=0 three cycles, WB writes Rt=0x55 in cycle 1 only -> SrcB=0x55 in cycles 2-3; InReady=0 throughout; with macro undefined SrcB stays original RD2.
REQ-035 Flush and InValid asserted same edge while valid -> OutValid=0 next cycle, RegWriteE=0, new instruction not captured.
REQ-036 rst_n asserted between edges while OutValid=1 -> OutValid=0, SrcA=0, ALUControl=7 without waiting for clk.
